display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clock cycles per digit slot (>= DEAD_CYCLES+2).
REQ-002 SHALL have parameter DEAD_CYCLES, default 100: anode-off cycles at the start of each slot (ghosting guard).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: scan enable; low means display dark.
REQ-006 SHALL have port lzb_en, input, 1 bit: enables leading-zero blanking.
REQ-007 SHALL have ports digit3..digit0, input, 4 bits each: BCD/hex digits, digit3 most significant.
REQ-008 SHALL have port state, input, 3 bits: vending state code (ERROR=5, THANK=6).
REQ-009 SHALL have port an, output, 4 bits: active-low anodes; bit k drives digit k.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new snapshot is taken.

Function
REQ-012 SHALL implement FSM OFF/DEAD/DRIVE: OFF while enable=0; OFF->DEAD when enable=1; DEAD->DRIVE after DEAD_CYCLES cycles; DRIVE->DEAD at slot end (prescaler = CLK_DIV-1); any state->OFF in the cycle after enable=0.
REQ-013 SHALL count the prescaler 0..CLK_DIV-1 and wrap, clearing it in OFF.
REQ-014 SHALL scan digit index in the order 3,2,1,0,3,...; the index advances at slot end and is forced to 3 in OFF.
REQ-015 SHALL latch all four digits and state into a snapshot, and pulse frame_start, on the OFF->DEAD transition and at every 0->3 index wrap.
REQ-016 SHALL use only the snapshot to drive outputs; input changes become visible at the next frame boundary, with no tearing within a frame.
REQ-017 SHALL drive an=4'b1111 and seg=7'h7F in OFF and DEAD; in DRIVE, an has only bit[index] low, unless the digit is blanked.
REQ-018 SHALL decode seg as hex 0-F, active-low (0=7'h40, 5=7'h12, D=7'h21, E=7'h06).
REQ-019 SHALL apply leading-zero blanking only when lzb_en=1 and the snapshot state is neither 5 nor 6: blank digit3 if it is 0; blank digit2 if digit3 and digit2 are both 0; never blank digit1 or digit0.
REQ-020 SHALL apply error blinking when the snapshot state=5: a frame counter toggles blink_phase every BLINK_FRAMES frames; while blink_phase=1 all anodes are off. On any other snapshot state the counter and phase clear to 0 at the frame boundary.
REQ-021 SHALL treat enable falling mid-slot as immediate blanking next cycle; re-enable restarts at digit3 with a fresh snapshot.
REQ-022 SHALL keep the blink frame counter width at $clog2(BLINK_FRAMES)+1 and saturate-free wrap at BLINK_FRAMES-1.

Reset
REQ-023 SHALL, on rst_n low asynchronously, set: FSM=OFF, an=4'b1111, seg=7'h7F, frame_start=0, index=3, prescaler=0, frame counter=0, blink_phase=0, snapshot=0.
REQ-024 SHALL register all outputs; release of reset takes effect at the first clk edge with rst_n high.

Structure
REQ-025 SHALL place FSM encodings, the vending state codes (IDLE=0, CHANGE=4, ERROR=5, THANK=6) and segment blank constant 7'h7F in a shared package display_pkg.
REQ-026 SHALL put hex-to-segment decoding in one combinational sub-module seg7_decoder.

Verification (bench parameters CLK_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2)
REQ-027 SHALL verify: reset, then enable=1 with digits 1,2,5,0 and state=2 -> frame_start at cycle 1; an=1111 for 2 cycles, then an=0111/seg=7'h79 for 6 cycles; then digit2 (7'h24), digit1 (7'h12), digit0 (7'h40), then wrap with frame_start.
REQ-028 SHALL verify: digit3 changed to 9 mid-frame -> seg still shows 1 until the next frame_start, then 7'h10.
REQ-029 SHALL verify: lzb_en=1 with digits 0,0,7,0 and state=2 -> an stays 1111 in the digit3 and digit2 slots; digit1 shows 7'h78.
REQ-030 SHALL verify: state=5 with digits E,E,0,0 -> 2 frames visible, 2 frames fully dark, repeating; state back to 2 -> no dark frames from the next frame.
REQ-031 SHALL verify: enable dropped in the DRIVE of digit1 -> an=1111/seg=7'h7F next cycle; re-enable -> scan restarts at digit3 with frame_start.
REQ-032 SHALL verify: rst_n asserted mid-DRIVE asynchronously -> all outputs reach reset values without waiting for a clk edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed display scanner.
package display_pkg;
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DEAD  = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHANGE = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;
  localparam logic [2:0] ST_THANK  = 3'd6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0][3:0] digits;
    logic [2:0]      state;
  } snap_t;
endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit scanner: per-frame snapshot, dead-time guard, leading-zero
// blanking and error blinking. Outputs are registered from next-state values.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned DEAD_CYCLES  = 100,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lzb_en,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [2:0] state,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] P_LAST    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST    = FW'(BLINK_FRAMES - 1);

  scan_state_e   fsm, fsm_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    idx, idx_nxt;
  snap_t         snap, snap_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          phase, phase_nxt;
  logic          slot_end, frame_bnd, lzb_act, blank, visible;
  logic [3:0]    cur_digit, an_nxt;
  logic [6:0]    seg_dec, seg_nxt;

  always_comb begin
    fsm_nxt   = fsm;
    presc_nxt = presc;
    idx_nxt   = idx;
    snap_nxt  = snap;
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    slot_end  = enable && (fsm == S_DRIVE) && (presc == P_LAST);
    frame_bnd = enable && ((fsm == S_OFF) || (slot_end && idx == 2'd0));

    if (!enable) fsm_nxt = S_OFF;
    else begin
      case (fsm)
        S_OFF:   fsm_nxt = S_DEAD;
        S_DEAD:  if (presc == DEAD_LAST) fsm_nxt = S_DRIVE;
        S_DRIVE: if (slot_end) fsm_nxt = S_DEAD;
        default: fsm_nxt = S_OFF;
      endcase
    end

    if (!enable || fsm == S_OFF) presc_nxt = '0;
    else presc_nxt = (presc == P_LAST) ? '0 : presc + PW'(1);

    if (!enable) idx_nxt = 2'd3;
    else if (slot_end) idx_nxt = idx - 2'd1;

    // Blink counts completed error frames; a non-error frame resets the cadence.
    if (frame_bnd) begin
      snap_nxt.digits = {digit3, digit2, digit1, digit0};
      snap_nxt.state  = state;
      if (state != ST_ERROR) begin
        fcnt_nxt  = '0;
        phase_nxt = 1'b0;
      end else if (snap.state == ST_ERROR) begin
        if (fcnt == F_LAST) begin
          fcnt_nxt  = '0;
          phase_nxt = ~phase;
        end else fcnt_nxt = fcnt + FW'(1);
      end
    end
  end

  assign cur_digit = snap_nxt.digits[idx_nxt];
  assign lzb_act   = lzb_en && (snap_nxt.state != ST_ERROR) && (snap_nxt.state != ST_THANK);
  assign blank     = lzb_act && (
                       (idx_nxt == 2'd3 && snap_nxt.digits[3] == 4'd0) ||
                       (idx_nxt == 2'd2 && snap_nxt.digits[3] == 4'd0 && snap_nxt.digits[2] == 4'd0));
  assign visible   = (fsm_nxt == S_DRIVE) && !blank && !phase_nxt;

  seg7_decoder u_dec (.hex(cur_digit), .seg(seg_dec));

  for (genvar k = 0; k < 4; k++) begin : g_an
    assign an_nxt[k] = !(visible && idx_nxt == 2'(k));
  end

  assign seg_nxt = visible ? seg_dec : SEG_BLANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= S_OFF;
      presc       <= '0;
      idx         <= 2'd3;
      snap        <= '0;
      fcnt        <= '0;
      phase       <= 1'b0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      fsm         <= fsm_nxt;
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      fcnt        <= fcnt_nxt;
      phase       <= phase_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= frame_bnd;
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a time-indexed scan model.
module tb_display_scan_controller;
  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int BF      = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       lzb_en = 1'b0;
  logic [3:0] digit3 = '0, digit2 = '0, digit1 = '0, digit0 = '0;
  logic [2:0] state = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int n_chk = 0;
  int n_err = 0;

  // model state: scan time since enable, latched frame contents, error streak
  bit         running = 0;
  int         t = 0;
  int         m_k = 3;
  int         m_pos = 0;
  logic [3:0] md [4];
  logic [2:0] mst = '0;
  int         ecount = 0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_fs;
  bit         seg_chk;

  display_scan_controller #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzb_en(lzb_en),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .state(state), .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    running = 0; t = 0; mst = '0; ecount = 0; m_k = 3; m_pos = 0;
    for (int i = 0; i < 4; i++) md[i] = '0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    bit blank, dark;
    @(posedge clk);
    e_fs = 1'b0;
    if (!enable) running = 0;
    else begin
      if (!running) begin running = 1; t = 0; end
      else t++;
      if (t % FRAME == 0) begin
        e_fs = 1'b1;
        if (state == 3'd5) ecount = (mst == 3'd5) ? ecount + 1 : 0;
        md[3] = digit3; md[2] = digit2; md[1] = digit1; md[0] = digit0;
        mst = state;
      end
    end
    e_an = 4'hF; e_seg = 7'h7F; seg_chk = 1;
    if (running) begin
      m_pos = t % CLK_DIV;
      m_k   = 3 - ((t / CLK_DIV) % 4);
      if (m_pos >= DEAD) begin
        blank = lzb_en && mst != 3'd5 && mst != 3'd6 &&
                ((m_k == 3 && md[3] == 0) || (m_k == 2 && md[3] == 0 && md[2] == 0));
        dark  = (mst == 3'd5) && (((ecount / BF) % 2) == 1);
        if (blank || dark) seg_chk = 0;
        else begin
          e_an  = ~(4'b0001 << m_k);
          e_seg = hex7(md[m_k]);
        end
      end
    end
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    if (seg_chk) chk("seg", 32'(seg), 32'(e_seg));
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d, input logic [2:0] s);
    digit3 = a; digit2 = b; digit1 = c; digit0 = d; state = s;
  endtask

  initial begin
    int hold;
    bit found;
    model_reset();
    #12;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic scan of 1,2,5,0, then digit3 changed mid-frame
    set_digits(4'd1, 4'd2, 4'd5, 4'd0, 3'd2);
    enable = 1'b1;
    repeat (12) step();
    digit3 = 4'd9;
    repeat (2 * FRAME) step();

    // leading-zero blanking
    lzb_en = 1'b1;
    set_digits(4'd0, 4'd0, 4'd7, 4'd0, 3'd2);
    repeat (2 * FRAME) step();

    // error blinking, then recovery
    set_digits(4'hE, 4'hE, 4'd0, 4'd0, 3'd5);
    repeat (7 * FRAME) step();
    state = 3'd2;
    repeat (2 * FRAME) step();

    // drop enable during digit1 drive, then re-enable
    lzb_en = 1'b0;
    set_digits(4'd3, 4'd4, 4'd5, 4'd6, 3'd0);
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      step();
      if (running && m_k == 1 && m_pos >= DEAD + 1) found = 1;
    end
    chk("reach_digit1", 32'(found), 32'h1);
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (FRAME + 4) step();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_digits(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom),
                   ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom),
                   4'($urandom), 4'($urandom), state);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 4))
          0: state = 3'd0; 1: state = 3'd2; 2: state = 3'd4; 3: state = 3'd5; default: state = 3'd6;
        endcase
      end
      if ($urandom_range(0, 99) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        hold = $urandom_range(1, 5);
        repeat (hold) step();
        enable = 1'b1;
      end
      step();
    end

    // asynchronous reset during a drive phase
    state = 3'd0; lzb_en = 1'b0;
    set_digits(4'd8, 4'd8, 4'd8, 4'd8, 3'd0);
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      if (running && m_pos >= DEAD + 1 && m_pos < CLK_DIV - 1 && t >= FRAME) found = 1;
    end
    chk("reach_drive", 32'(found), 32'h1);
    chk("pre_rst_an", 32'(an == 4'hF), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_fs", 32'(frame_start), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
